// File: rtl/sub_serial.sv
// sub_serial: bit-serial W-bit subtractor (a - b - bi), LSB first, one bit per cycle.
// Define SUB_SERIAL_OVF_EN to add the signed-overflow output ovf.
module sub_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bo
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic br_q, br_d, bo_q, bo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-2:0] idx;
  logic run, accept, last, ai, bb, d, br_nx;
`ifdef SUB_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
`endif
  always_comb begin
    run = state_q == RUN;
    accept = !run && start;
    last = cnt_q == CW'(W - 1);
    idx = cnt_q[CW-2:0];
    ai = a_q[idx];
    bb = b_q[idx];
    d = ai ^ bb ^ br_q;
    br_nx = (~ai & bb) | (~(ai ^ bb) & br_q);
    state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
    a_d = accept ? a : a_q;
    b_d = accept ? b : b_q;
    br_d = accept ? bi : run ? br_nx : br_q;
    cnt_d = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    diff_d = run ? {d, diff_q[W-1:1]} : diff_q;
    bo_d = (run && last) ? br_nx : bo_q;
`ifdef SUB_SERIAL_OVF_EN
    // d is the final MSB of diff on the last RUN cycle
    ovf_d = (run && last) ? ((a_q[W-1] != b_q[W-1]) && (d != a_q[W-1])) : ovf_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      br_q <= 1'b0;
      cnt_q <= '0;
      diff_q <= '0;
      bo_q <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      br_q <= br_d;
      cnt_q <= cnt_d;
      diff_q <= diff_d;
      bo_q <= bo_d;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign diff = diff_q;
  assign bo = bo_q;
`ifdef SUB_SERIAL_OVF_EN
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed checks of sub_serial at W=4 with hand-computed results.
module tb_sub_serial;
  logic clk = 1'b0;
  logic rst, start, bi, busy, done, bo;
  logic [3:0] a, b, diff;
`ifdef SUB_SERIAL_OVF_EN
  logic ovf;
`endif
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  always #5 clk = ~clk;
  sub_serial #(.W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
    .busy(busy), .done(done), .diff(diff), .bo(bo)
`ifdef SUB_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );
  always @(negedge clk) if (done) done_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                        input logic tbi, input logic [3:0] ed, input logic eb, input logic eo);
    int n;
    a = ta;
    b = tb;
    bi = tbi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " diff"}, 32'(diff), 32'(ed));
    check({tag, " bo"}, 32'(bo), 32'(eb));
    check({tag, " busy_done"}, 32'(busy), 0);
`ifdef SUB_SERIAL_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation in %s", tag);
`endif
  endtask
  initial begin
    int base;
    rst = 1'b1;
    start = 1'b1;
    a = 4'hF;
    b = 4'h1;
    bi = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst diff", 32'(diff), 0);
    check("rst bo", 32'(bo), 0);
`ifdef SUB_SERIAL_OVF_EN
    check("rst ovf", 32'(ovf), 0);
`endif
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("t9m3", 4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("hold done", 32'(done), 0);
    check("hold diff", 32'(diff), 6);
    run_op("t3m9", 4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    run_op("t0m0b", 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    run_op("t8m1", 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1);
    run_op("b2b", 4'h7, 4'h2, 1'b1, 4'h4, 1'b0, 1'b0);
    run_op("tFmFb", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("idle diff", 32'(diff), 15);
    check("idle bo", 32'(bo), 1);
    check("idle busy", 32'(busy), 0);
    base = done_cnt;
    a = 4'h5;
    b = 4'h2;
    bi = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    a = 4'hF;
    b = 4'hF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("ign done", 32'(done), 1);
    check("ign diff", 32'(diff), 3);
    check("ign bo", 32'(bo), 0);
    repeat (8) @(posedge clk);
    #1;
    check("ign pulses", done_cnt - base, 1);
    a = 4'h6;
    b = 4'h1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = done_cnt;
    check("mid busy", 32'(busy), 0);
    check("mid done", 32'(done), 0);
    check("mid diff", 32'(diff), 0);
    check("mid bo", 32'(bo), 0);
    repeat (8) @(posedge clk);
    #1;
    check("mid pulses", done_cnt - base, 0);
    run_op("tCm4", 4'hC, 4'h4, 1'b0, 4'h8, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
